// File: rtl/hilo_mult_div_unit_if.sv
// hilo_mult_div_unit_if: launch/result bundle between the execute stage and
// the HI/LO multiply/divide unit.
//
// Handshake: Start is sampled on every rising edge. It is accepted only while
// Busy=0 and Op is a valid code. A multiply/divide raises Busy after its
// launch edge and keeps it high until the edge that writes Hi/Lo. That edge
// pulses Done for one cycle, and DivZero with it for a zero divisor. MTHI/MTLO
// complete on their launch edge, pulse Done, and never raise Busy. A Start
// sampled while Busy=1 is dropped, not queued.
interface hilo_mult_div_unit_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  modport master (output Start, Op, A, B, input Busy, Done, DivZero, Hi, Lo);
  modport slave  (input Start, Op, A, B, output Busy, Done, DivZero, Hi, Lo);
endinterface

// File: rtl/hilo_mult_div_unit.sv
// hilo_mult_div_unit: iterative 32x32 multiply / 32/32 divide that owns the
// MIPS HI/LO pair. One iteration runs per cycle, with 32 iterations, then one
// sign-fix cycle.
// Optional feature macro HILO_DIV_EN: when defined, DIV/DIVU are built.
// Otherwise those opcodes are ignored and DivZero is tied low.
module hilo_mult_div_unit (
  input  logic                       Clk,
  input  logic                       Reset_n,
  hilo_mult_div_unit_if.slave        bus,
  output logic [1:0]                 state_dbg
);
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef HILO_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q, acc_step;   // product accumulator or {remainder, quotient}
  logic [31:0] opnd_q;            // multiplicand or divisor magnitude
  logic        signed_q, sign_a_q, sign_b_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;
  logic        launch_md, launch_mt, op_signed;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;
`ifdef HILO_DIV_EN
  logic        is_div_q, dz_q, divzero_q;
  logic [31:0] raw_a_q;
  logic [32:0] rem_sh, rem_diff;
  logic [31:0] quo_fix, rem_fix;
`endif

  assign bus.Busy  = (state_q != IDLE);
  assign bus.Done  = done_q;
  assign bus.Hi    = hi_q;
  assign bus.Lo    = lo_q;
  assign state_dbg = state_q;
`ifdef HILO_DIV_EN
  assign bus.DivZero = divzero_q;
`else
  assign bus.DivZero = 1'b0;
`endif

  // Launch decode: only an idle unit accepts Start, and invalid codes are dropped.
  always_comb begin
    launch_md = 1'b0;
    launch_mt = 1'b0;
    if (state_q == IDLE && bus.Start) begin
      case (bus.Op)
        OP_MULT, OP_MULTU: launch_md = 1'b1;
`ifdef HILO_DIV_EN
        OP_DIV, OP_DIVU:   launch_md = 1'b1;
`endif
        OP_MTHI, OP_MTLO:  launch_mt = 1'b1;
        default:           ;
      endcase
    end
  end

  // Signed ops (MULT, DIV) have Op[0]=0; their operands are iterated as magnitudes.
  always_comb begin
    op_signed = ~bus.Op[0];
    mag_a     = (op_signed && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
    mag_b     = (op_signed && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;
  end

  // Next-state logic for the IDLE -> CALC -> FIX sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch_md) state_d = CALC;
      CALC:    if (cnt_q == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration: shift-add multiply, or restoring shift-subtract divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    acc_step = {mul_sum, acc_q[31:1]};
`ifdef HILO_DIV_EN
    rem_sh   = acc_q[63:31];
    rem_diff = rem_sh - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!rem_diff[32]) acc_step = {rem_diff[31:0], acc_q[30:0], 1'b1};
      else               acc_step = {rem_sh[31:0], acc_q[30:0], 1'b0};
    end
`endif
  end

  // Sign correction applied in FIX. The remainder follows the dividend's sign.
  always_comb begin
    prod_fix = (signed_q && (sign_a_q ^ sign_b_q)) ? (~acc_q + 64'd1) : acc_q;
`ifdef HILO_DIV_EN
    quo_fix  = (signed_q && (sign_a_q ^ sign_b_q)) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = (signed_q && sign_a_q) ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
`endif
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath, HI/LO, and the Done/DivZero pulses.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      signed_q  <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef HILO_DIV_EN
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      divzero_q <= 1'b0;
      raw_a_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef HILO_DIV_EN
      divzero_q <= 1'b0;
`endif
      if (launch_mt) begin
        if (bus.Op[0]) lo_q <= bus.A;
        else           hi_q <= bus.A;
        done_q <= 1'b1;
      end
      if (launch_md) begin
        cnt_q    <= '0;
        signed_q <= op_signed;
        sign_a_q <= op_signed & bus.A[31];
        sign_b_q <= op_signed & bus.B[31];
`ifdef HILO_DIV_EN
        is_div_q <= bus.Op[1];
        dz_q     <= (bus.B == 32'd0);
        raw_a_q  <= bus.A;
        if (bus.Op[1]) begin
          acc_q  <= {32'd0, mag_a};
          opnd_q <= mag_b;
        end else
`endif
        begin
          acc_q  <= {32'd0, mag_b};
          opnd_q <= mag_a;
        end
      end
      if (state_q == CALC) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 5'd1;
      end
      if (state_q == FIX) begin
        done_q <= 1'b1;
`ifdef HILO_DIV_EN
        if (is_div_q) begin
          if (dz_q) begin
            hi_q      <= raw_a_q;
            lo_q      <= 32'hFFFF_FFFF;
            divzero_q <= 1'b1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end else
`endif
        begin
          hi_q <= prod_fix[63:32];
          lo_q <= prod_fix[31:0];
        end
      end
    end
  end
endmodule
